// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory bus responder.
//   XLEN          : processor address width
//   MEM_TAG_BITS  : width of transaction tags (tag 0 means "none")
//   BUS_COMMAND   : bus command encoding driven by the load/store queue
//   MEM_TAG_SLOT  : per-tag in-flight transaction record
package data_mem_responder_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MEM_TAG_BITS = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic        valid;
    logic [4:0]  countdown;
    logic [63:0] data;
  } MEM_TAG_SLOT;

endpackage

// File: rtl/data_mem_responder_tag_allocator.sv
// Lowest-free-index priority encoder over the tag slot valid vector.
//   slot_valid : bit i set when tag i+1 is allocated
//   grant_tag  : lowest free tag (1..NUM_TAGS), 0 when none is free
//   none_free  : every tag is allocated
module mem_tag_allocator
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 15
) (
  input  logic [NUM_TAGS-1:0]     slot_valid,
  output logic [MEM_TAG_BITS-1:0] grant_tag,
  output logic                    none_free
);

  logic found;

  always_comb begin
    grant_tag = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!found && !slot_valid[i]) begin
        grant_tag = MEM_TAG_BITS'(i + 1);
        found     = 1'b1;
      end
    end
    none_free = !found;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the LSQ data-memory bus.
//   clock, reset        : system clock; asynchronous active-low reset
//   proc2mem_command    : BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2mem_addr       : byte address, dword index taken from bits [3 +: log2(MEM_DWORDS)]
//   proc2mem_data       : store data
//   stall_req           : force rejection of this cycle's command
//   mem2proc_response   : tag granted this cycle (combinational), 0 = rejected/no command
//   mem2proc_tag/_data  : registered completion report, tag 0 = none
//   outstanding_cnt     : number of allocated tags
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned NUM_TAGS    = 15,
  parameter int unsigned MEM_DWORDS  = 8192
) (
  input  logic                    clock,
  input  logic                    reset,
  input  BUS_COMMAND              proc2mem_command,
  input  logic [XLEN-1:0]         proc2mem_addr,
  input  logic [63:0]             proc2mem_data,
  input  logic                    stall_req,
  output logic [MEM_TAG_BITS-1:0] mem2proc_response,
  output logic [63:0]             mem2proc_data,
  output logic [MEM_TAG_BITS-1:0] mem2proc_tag,
  output logic [MEM_TAG_BITS-1:0] outstanding_cnt
);

  localparam int unsigned IDX_BITS = $clog2(MEM_DWORDS);
  localparam logic [4:0]  LAT      = 5'(MEM_LATENCY);

  logic [63:0]             mem [MEM_DWORDS];
  MEM_TAG_SLOT             slots [NUM_TAGS];   // slots[i] holds tag i+1
  logic [NUM_TAGS-1:0]     valid_vec;
  logic [MEM_TAG_BITS-1:0] grant_tag;
  logic                    none_free;
  logic [IDX_BITS-1:0]     idx;
  logic                    accept;
  logic [63:0]             accept_data;
  logic                    unused_addr_bits;

  mem_tag_allocator #(.NUM_TAGS(NUM_TAGS)) u_alloc (
    .slot_valid (valid_vec),
    .grant_tag  (grant_tag),
    .none_free  (none_free)
  );

  assign idx              = proc2mem_addr[3 +: IDX_BITS];
  assign unused_addr_bits = ^{proc2mem_addr[XLEN-1:3+IDX_BITS], proc2mem_addr[2:0]};

  always_comb begin
    outstanding_cnt = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      valid_vec[i]    = slots[i].valid;
      outstanding_cnt = outstanding_cnt + MEM_TAG_BITS'(slots[i].valid);
    end
    accept            = reset && (proc2mem_command != BUS_NONE) && !stall_req && !none_free;
    mem2proc_response = accept ? grant_tag : '0;
    accept_data       = (proc2mem_command == BUS_LOAD) ? mem[idx] : '0;
  end

  // Backing array is intentionally outside the reset domain.
  always_ff @(posedge clock) begin
    if (accept && proc2mem_command == BUS_STORE) begin
      mem[idx] <= proc2mem_data;
    end
  end

  // A slot with countdown 2 completes next cycle, so the registered report is
  // loaded one edge early; with latency 1 it is loaded straight from acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        slots[i] <= '0;
      end
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
    end else begin
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        if (slots[i].valid) begin
          slots[i].countdown <= slots[i].countdown - 5'd1;
          if (slots[i].countdown == 5'd1) begin
            slots[i].valid <= 1'b0;
          end
          if (slots[i].countdown == 5'd2) begin
            mem2proc_tag  <= MEM_TAG_BITS'(i + 1);
            mem2proc_data <= slots[i].data;
          end
        end
        if (accept && grant_tag == MEM_TAG_BITS'(i + 1)) begin
          slots[i] <= '{valid: 1'b1, countdown: LAT, data: accept_data};
        end
      end
      if (MEM_LATENCY == 1 && accept) begin
        mem2proc_tag  <= grant_tag;
        mem2proc_data <= accept_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (latency 10 / 15 tags, latency 10 / 3 tags, latency 1 / 15 tags)
// share one stimulus stream; each is checked against a transaction-list model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned ND = 3;
  localparam int unsigned DW = 8192;

  logic                    clock = 1'b0;
  logic                    reset;
  BUS_COMMAND              cmd;
  logic [XLEN-1:0]         addr;
  logic [63:0]             wdata;
  logic                    stall;
  logic [MEM_TAG_BITS-1:0] resp  [ND];
  logic [63:0]             rdata [ND];
  logic [MEM_TAG_BITS-1:0] rtag  [ND];
  logic [MEM_TAG_BITS-1:0] cnt   [ND];

  always #5 clock = ~clock;

  data_mem_responder #(.MEM_LATENCY(10), .NUM_TAGS(15), .MEM_DWORDS(DW)) dut_a (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .stall_req(stall), .mem2proc_response(resp[0]),
    .mem2proc_data(rdata[0]), .mem2proc_tag(rtag[0]), .outstanding_cnt(cnt[0]));

  data_mem_responder #(.MEM_LATENCY(10), .NUM_TAGS(3), .MEM_DWORDS(DW)) dut_b (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .stall_req(stall), .mem2proc_response(resp[1]),
    .mem2proc_data(rdata[1]), .mem2proc_tag(rtag[1]), .outstanding_cnt(cnt[1]));

  data_mem_responder #(.MEM_LATENCY(1), .NUM_TAGS(15), .MEM_DWORDS(DW)) dut_c (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .stall_req(stall), .mem2proc_response(resp[2]),
    .mem2proc_data(rdata[2]), .mem2proc_tag(rtag[2]), .outstanding_cnt(cnt[2]));

  function automatic int unsigned lat_of(input int unsigned k);
    return (k == 2) ? 1 : 10;
  endfunction

  function automatic int unsigned tags_of(input int unsigned k);
    return (k == 1) ? 3 : 15;
  endfunction

  typedef struct {
    int unsigned dut;
    int unsigned tag;
    int unsigned done;
    logic [63:0] data;
    bit          known;
  } txn_t;

  txn_t        q[$];
  logic [63:0] mdata [int unsigned];
  int unsigned cyc;
  int          ntests = 0;
  int          nfail  = 0;

  task automatic chk(input string name, input int unsigned k,
                     input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    txn_t keep[$];
    for (int unsigned k = 0; k < ND; k++) begin
      logic [63:0] exp_data;
      int unsigned exp_tag, held, n, gt, key;
      bit          dknown;
      txn_t        t;
      exp_data = '0; exp_tag = 0; held = 0; n = 0; gt = 0; dknown = 1'b1;
      foreach (q[j]) begin
        if (q[j].dut == k) begin
          held = held | (32'd1 << q[j].tag);
          n++;
          if (q[j].done == cyc) begin
            exp_tag  = q[j].tag;
            exp_data = q[j].data;
            dknown   = q[j].known;
          end
        end
      end
      chk("tag", k, 64'(rtag[k]), 64'(exp_tag));
      if (dknown) chk("data", k, rdata[k], exp_data);
      chk("outstanding", k, 64'(cnt[k]), 64'(n));
      for (int unsigned tg = tags_of(k); tg >= 1; tg--) begin
        if (!held[tg]) gt = tg;
      end
      if (!reset || cmd == BUS_NONE || stall) gt = 0;
      chk("response", k, 64'(resp[k]), 64'(gt));
      if (gt != 0) begin
        key    = k * DW + ((addr >> 3) % DW);
        t.dut  = k;
        t.tag  = gt;
        t.done = cyc + lat_of(k);
        if (cmd == BUS_STORE) begin
          mdata[key] = wdata;
          t.data     = '0;
          t.known    = 1'b1;
        end else begin
          t.known = mdata.exists(key);
          t.data  = t.known ? mdata[key] : '0;
        end
        q.push_back(t);
      end
    end
    foreach (q[j]) if (q[j].done != cyc) keep.push_back(q[j]);
    q = keep;
  endtask

  task automatic step(input BUS_COMMAND c, input logic [XLEN-1:0] a,
                      input logic [63:0] d, input logic s, input logic r);
    @(posedge clock);
    cyc++;
    #1;
    cmd = c; addr = a; wdata = d; stall = s; reset = r;
    if (!r) q.delete();
    @(negedge clock);
    check_cycle();
  endtask

  function automatic logic [XLEN-1:0] mk_addr(input int unsigned idx5);
    logic [15:0] hi;
    logic [2:0]  lo;
    hi = 16'($urandom);
    lo = 3'($urandom);
    return {hi, 8'h00, 5'(idx5), lo};
  endfunction

  initial begin
    reset = 1'b0; cmd = BUS_LOAD; addr = '0; wdata = '0; stall = 1'b0; cyc = 0;
    #3;
    for (int unsigned k = 0; k < ND; k++) begin
      chk("rst_tag", k, 64'(rtag[k]), 64'd0);
      chk("rst_data", k, rdata[k], 64'd0);
      chk("rst_cnt", k, 64'(cnt[k]), 64'd0);
      chk("rst_resp", k, 64'(resp[k]), 64'd0);
    end
    repeat (2) @(posedge clock);

    // Prefill dwords 0..31 (upper address bits random to exercise aliasing).
    for (int unsigned i = 0; i < 32; i++) begin
      step(BUS_STORE, mk_addr(i), (i == 5) ? 64'hDEAD_BEEF : {$urandom, $urandom}, 1'b0, 1'b1);
    end
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Single load of dword 5, then store-then-load on dword 8.
    step(BUS_LOAD, 32'h0000_0028, '0, 1'b0, 1'b1);
    step(BUS_STORE, 32'h0000_0040, 64'h1234, 1'b0, 1'b1);
    step(BUS_LOAD, 32'h0000_0040, '0, 1'b0, 1'b1);
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Pool exhaustion on the 3-tag responder with continuous retry.
    for (int unsigned i = 0; i < 4; i++) step(BUS_LOAD, mk_addr(i), '0, 1'b0, 1'b1);
    chk("full_reject", 1, 64'(resp[1]), 64'd0);
    repeat (8) step(BUS_LOAD, mk_addr(3), '0, 1'b0, 1'b1);
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Stall injection then clean retry.
    step(BUS_LOAD, mk_addr(7), '0, 1'b1, 1'b1);
    for (int unsigned k = 0; k < ND; k++) chk("stall_resp", k, 64'(resp[k]), 64'd0);
    step(BUS_LOAD, mk_addr(7), '0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < ND; k++) chk("retry_resp", k, 64'(resp[k]), 64'd1);
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Reset in flight: three loads, then a one-cycle reset pulse.
    for (int unsigned i = 0; i < 3; i++) step(BUS_LOAD, mk_addr(i + 10), '0, 1'b0, 1'b1);
    step(BUS_NONE, '0, '0, 1'b0, 1'b1);
    step(BUS_LOAD, mk_addr(1), '0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < ND; k++) chk("midrst_cnt", k, 64'(cnt[k]), 64'd0);
    repeat (14) step(BUS_NONE, '0, '0, 1'b0, 1'b1);
    step(BUS_LOAD, mk_addr(2), '0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < ND; k++) chk("post_rst_tag1", k, 64'(resp[k]), 64'd1);
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Latency-1 back-to-back loads.
    for (int unsigned i = 0; i < 20; i++) step(BUS_LOAD, mk_addr(i), '0, 1'b0, 1'b1);
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    // Randomized traffic with occasional reset pulses.
    for (int unsigned i = 0; i < 600; i++) begin
      int unsigned   sel;
      BUS_COMMAND    c;
      sel = $urandom_range(0, 9);
      c   = (sel < 3) ? BUS_NONE : (sel < 7) ? BUS_LOAD : BUS_STORE;
      step(c, mk_addr($urandom_range(0, 31)), {$urandom, $urandom},
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 149) != 0));
    end
    repeat (12) step(BUS_NONE, '0, '0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the data-memory bus that the load/store queue drives. It accepts BUS_LOAD/BUS_STORE commands, answers each accepted command in the same cycle with a nonzero transaction tag, and returns the tag plus load data a fixed number of cycles later. It owns a dword-addressed backing array and a bounded tag pool. It sits opposite the LSQ in testbenches and in the synthesizable top, and serves as the reference target for LSQ retry and out-of-order-return verification.

## Interface
- MEM_LATENCY, 10: cycles from acceptance to completion report; legal range 1..31.
- NUM_TAGS, 15: maximum outstanding transactions; legal range 1..15; tags 1..NUM_TAGS.
- MEM_DWORDS, 8192: backing array depth in 64-bit dwords; power of two.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low (asserted when 0).
- proc2mem_command  input  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE.
- proc2mem_addr  input  `XLEN  byte address; bits [2:0] ignored.
- proc2mem_data  input  64  store data.
- stall_req  input  1  forces rejection of this cycle's command (retry injection).
- mem2proc_response  output  4  tag granted this cycle; 0 = rejected/no command.
- mem2proc_data  output  64  load data for completing tag; 0 otherwise.
- mem2proc_tag  output  4  tag completing this cycle; 0 = none.
- outstanding_cnt  output  4  number of allocated tags.

## Operation
- Index = proc2mem_addr[3 +: $clog2(MEM_DWORDS)]; upper address bits are ignored (addresses alias modulo the array size).
- Acceptance condition: command != BUS_NONE, stall_req == 0, reset deasserted, at least one free tag.
- On acceptance, the granted tag is the lowest-numbered free tag. The slot records a valid bit, a countdown equal to MEM_LATENCY, and data.
- BUS_LOAD: slot data = array[index], read combinationally in the acceptance cycle. Stores accepted earlier are visible.
- BUS_STORE: array[index] <= proc2mem_data at the acceptance edge. Slot data = 0. A store also completes with its tag.
- Each valid slot decrements its countdown every cycle. The slot whose countdown reaches 0 drives mem2proc_tag/mem2proc_data for one cycle and is freed at the end of that cycle.
- At most one completion occurs per cycle. This is guaranteed because latency is fixed and acceptance is at most one per cycle.
- A rejected command has no side effects. The array is not written, and the requester must retry.
- outstanding_cnt = popcount of valid slots (registered state).

## Timing
- mem2proc_response is combinational (Mealy) from command/stall_req/free-tag state in the same cycle.
- Accepted in cycle t → mem2proc_tag = tag in cycle t+MEM_LATENCY exactly. mem2proc_tag and mem2proc_data are registered outputs.
- A freed tag becomes allocatable in cycle t+MEM_LATENCY+1. There is no same-cycle reuse.
- Full: with NUM_TAGS outstanding, response = 0. If a completion occurs in the same cycle, the acceptance is still rejected that cycle.
- Reset assertion (any time, asynchronous): all slots are invalidated, and mem2proc_tag, mem2proc_data and outstanding_cnt go to 0 immediately. In-flight completions are dropped. Stores already accepted remain written.
- Array contents are not cleared by reset. In simulation, power-on contents are zero.
- Reset values: mem2proc_tag=0, mem2proc_data=0, outstanding_cnt=0. mem2proc_response=0 while reset is asserted.

## Structure
- Shared package (sys_defs):
  - BUS_COMMAND (already shared).
  - New typedef MEM_TAG_SLOT {valid, countdown[4:0], data[63:0]}.
  - Constant MEM_TAG_BITS = 4.
- Sub-module mem_tag_allocator: a lowest-free-index priority encoder over the slot valid vector, outputting grant tag and a none_free flag.
- Slot array, countdown logic and backing array live in the top module.

## Test plan
- Single load: with MEM_LATENCY=10, array[5]=64'hDEAD_BEEF, issue LOAD at 0x28 in cycle 3 → response=1 in cycle 3; in cycle 13, tag=1 and data=64'hDEAD_BEEF; tag=0 in cycles 4..12 and 14.
- Store-then-load: STORE 0x40 data 64'h1234 in cycle 0, then LOAD 0x40 in cycle 1 → responses 1, 2; completions: tag 1 with data 0 in cycle 10, tag 2 with data 64'h1234 in cycle 11.
- Full pool: NUM_TAGS=3, four back-to-back LOADs → responses 1, 2, 3, 0; the fourth is retried every cycle and accepted with tag 1 exactly in the cycle after tag 1 completes.
- Stall injection: LOAD with stall_req=1 → response=0, outstanding_cnt unchanged, no completion; the same LOAD next cycle with stall_req=0 → response=1.
- Reset mid-flight: three loads outstanding, reset pulled low for 1 cycle → tag/data/outstanding_cnt are 0 immediately and none of the three tags ever completes; the next load gets tag 1.
- MEM_LATENCY=1 back-to-back: loads every cycle for 20 cycles → each completes the next cycle with matching data; tags alternate 1, 2, 1, 2.
